// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard, forwarding and ISA-switch sequencing controller for the 5-stage core
module pipeline_ctrl #(
    parameter bit ARM_RESET    = 1'b0,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        LoadE,
    input  logic        armE,
    input  logic        PCSrcE,
    input  logic        SwitchE,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        RedirectF,
    output logic        armF,
    output logic [15:0] StallCount
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {S_RUN, S_MEMWAIT, S_DRAIN, S_SWITCH} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           arm_q, arm_d;
    logic [15:0]    stall_cnt_q, stall_cnt_d;

    logic           mem_wait;
    logic           run_mem_stall;
    logic           load_use;

    // x0 is hardwired in RISC-V; r15 is the PC in ARM and never forwarded
    function automatic logic reg_valid(input logic [4:0] r, input logic arm);
        return arm ? (r != 5'd15) : (r != 5'd0);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM && rs == RdM && reg_valid(rs, armE)) begin
            return 2'b10;
        end else if (RegWriteW && rs == RdW && reg_valid(rs, armE)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign mem_wait      = MemReqM & ~MemReadyM;
    assign run_mem_stall = (state_q == S_MEMWAIT) ? ~MemReadyM : mem_wait;
    assign load_use      = LoadE && reg_valid(RdE, armE) && (RdE == Rs1D || RdE == Rs2D);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_RUN;
            cnt_q       <= '0;
            arm_q       <= ARM_RESET;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            arm_q       <= arm_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            // The release cycle of a memory wait behaves exactly like RUN
            S_RUN, S_MEMWAIT: begin
                if (run_mem_stall) begin
                    state_d = S_MEMWAIT;
                end else if (PCSrcE) begin
                    state_d = S_RUN;
                end else if (SwitchE) begin
                    state_d = S_DRAIN;
                    cnt_d   = CNT_INIT;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (!mem_wait) begin
                    if (cnt_q == '0) begin
                        state_d = S_SWITCH;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            S_SWITCH: state_d = S_RUN;
            default:  state_d = S_RUN;
        endcase
    end

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        RedirectF = 1'b0;
        if (!rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else begin
            ForwardAE = fwd_sel(Rs1E);
            ForwardBE = fwd_sel(Rs2E);
            unique case (state_q)
                S_RUN, S_MEMWAIT: begin
                    if (run_mem_stall) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        StallM = 1'b1;
                        FlushW = 1'b1;
                    end else if (PCSrcE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (SwitchE) begin
                        StallF = 1'b1;
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (load_use) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                S_DRAIN: begin
                    StallF = 1'b1;
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                    if (mem_wait) begin
                        StallD = 1'b1;
                        StallE = 1'b1;
                        StallM = 1'b1;
                        FlushW = 1'b1;
                    end
                end
                S_SWITCH: begin
                    RedirectF = 1'b1;
                    FlushD    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        arm_d       = (state_q == S_SWITCH) ? ~arm_q : arm_q;
        stall_cnt_d = stall_cnt_q;
        if (StallF && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    assign armF       = arm_q;
    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl with a cycle-level reference model
module tb_pipeline_ctrl;

    localparam bit ARM_RESET    = 1'b0;
    localparam int DRAIN_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW, LoadE, armE, PCSrcE, SwitchE, MemReqM, MemReadyM;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, RedirectF, armF;
    logic [15:0] StallCount;

    pipeline_ctrl #(.ARM_RESET(ARM_RESET), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .LoadE(LoadE), .armE(armE),
        .PCSrcE(PCSrcE), .SwitchE(SwitchE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .RedirectF(RedirectF),
        .armF(armF), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [28:0] v;
        string       name;
    } exp_t;

    exp_t  sb_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "reset";

    // Reference model state: ISA mode, stall counter, cycles left in the switch sequence
    logic        m_arm;
    int          m_cnt;
    int          m_sw;

    wire [28:0] got = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                       FlushD, FlushE, FlushW, RedirectF, armF, StallCount};

    function automatic logic vld(input logic [4:0] r, input logic arm);
        return arm ? (r != 5'd15) : (r != 5'd0);
    endfunction

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (RegWriteM && rs == RdM && vld(rs, armE)) return 2'b10;
        if (RegWriteW && rs == RdW && vld(rs, armE)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clr();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteM, RegWriteW, LoadE, armE, PCSrcE, SwitchE, MemReqM} = '0;
        MemReadyM = 1'b1;
    endtask

    // Predict this cycle's outputs from the applied inputs, queue them, advance the model, then wait a cycle
    task automatic step();
        exp_t e;
        logic [1:0] fa, fb;
        logic sf, sd, se, sm, fd, fe, fw, rd, memw;
        {sf, sd, se, sm, fd, fe, fw, rd} = '0;
        fa = 2'b00;
        fb = 2'b00;
        memw = MemReqM && !MemReadyM;
        if (!rst) begin
            m_arm = ARM_RESET;
            m_cnt = 0;
            m_sw  = -1;
            fd = 1'b1;
            fe = 1'b1;
        end else begin
            fa = fwd(Rs1E);
            fb = fwd(Rs2E);
            if (m_sw == 0) begin
                rd = 1'b1; fd = 1'b1;
            end else if (m_sw > 0) begin
                sf = 1'b1; fd = 1'b1; fe = 1'b1;
                if (memw) begin sd = 1'b1; se = 1'b1; sm = 1'b1; fw = 1'b1; end
            end else if (memw) begin
                sf = 1'b1; sd = 1'b1; se = 1'b1; sm = 1'b1; fw = 1'b1;
            end else if (PCSrcE) begin
                fd = 1'b1; fe = 1'b1;
            end else if (SwitchE) begin
                sf = 1'b1; fd = 1'b1; fe = 1'b1;
            end else if (LoadE && vld(RdE, armE) && (RdE == Rs1D || RdE == Rs2D)) begin
                sf = 1'b1; sd = 1'b1; fe = 1'b1;
            end
        end
        e.v = {fa, fb, sf, sd, se, sm, fd, fe, fw, rd, m_arm, 16'(m_cnt)};
        e.name = phase;
        sb_q.push_back(e);
        if (rst) begin
            if (sf && m_cnt < 65535) m_cnt++;
            if (m_sw == 0) begin
                m_arm = ~m_arm;
                m_sw  = -1;
            end else if (m_sw > 0) begin
                if (!memw) m_sw--;
            end else if (!memw && !PCSrcE && SwitchE) begin
                m_sw = DRAIN_CYCLES;
            end
        end
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_tests++;
                if (got !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got fa%b fb%b sFDEM%b fDEW%b redir%b arm%b cnt%0d, want fa%b fb%b sFDEM%b fDEW%b redir%b arm%b cnt%0d",
                             e.name, got[28:27], got[26:25], got[24:21], got[20:18], got[17], got[16], got[15:0],
                             e.v[28:27], e.v[26:25], e.v[24:21], e.v[20:18], e.v[17], e.v[16], e.v[15:0]);
                end
            end
        end
    end

    initial begin : stimulus
        m_arm = ARM_RESET;
        m_cnt = 0;
        m_sw  = -1;
        clr();
        rst = 1'b0;
        @(negedge clk);
        repeat (3) step();
        rst = 1'b1;

        phase = "rv_fwd_m_over_w";
        RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 5;
        step();
        phase = "rv_fwd_x0";
        RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 0;
        step();
        phase = "arm_fwd_r0";
        clr(); armE = 1; RegWriteM = 1; RdM = 0; Rs1E = 0; Rs2E = 7;
        step();
        phase = "arm_fwd_r15";
        RdM = 15; Rs1E = 15;
        step();

        phase = "load_use";
        clr(); LoadE = 1; RdE = 3; Rs2D = 3;
        step();
        phase = "after_load_use";
        clr();
        step();
        phase = "load_use_branch";
        LoadE = 1; RdE = 3; Rs2D = 3; PCSrcE = 1;
        step();

        phase = "mem_wait";
        clr(); MemReqM = 1; MemReadyM = 0;
        step();
        PCSrcE = 1;
        step();
        PCSrcE = 0;
        step();
        phase = "mem_release";
        MemReadyM = 1; PCSrcE = 1;
        step();
        clr();
        step();

        phase = "switch";
        SwitchE = 1;
        step();
        clr();
        repeat (4) step();

        phase = "switch_reset";
        SwitchE = 1;
        step();
        clr();
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        phase = "after_switch_reset";
        repeat (5) step();

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] pool [7];
            logic hold_req;
            hold_req = MemReqM && !MemReadyM;
            pool = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd15, 5'd7, 5'd0};
            pool[6] = 5'($urandom_range(0, 31));
            Rs1D = pool[$urandom_range(0, 6)];
            Rs2D = pool[$urandom_range(0, 6)];
            Rs1E = pool[$urandom_range(0, 6)];
            Rs2E = pool[$urandom_range(0, 6)];
            RdE  = pool[$urandom_range(0, 6)];
            RdM  = pool[$urandom_range(0, 6)];
            RdW  = pool[$urandom_range(0, 6)];
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            LoadE     = ($urandom_range(0, 2) == 0);
            armE      = 1'($urandom_range(0, 1));
            PCSrcE    = ($urandom_range(0, 5) == 0);
            SwitchE   = ($urandom_range(0, 11) == 0);
            MemReqM   = hold_req || ($urandom_range(0, 5) == 0);
            MemReadyM = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 299) != 0);
            step();
        end

        rst = 1'b1;
        clr();
        @(negedge clk);
        #5;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_scoreboard: %0d entries left, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
